// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-level round functions.
// Byte 0 of a 128-bit block sits in [127:120]; bytes are column-major.
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Rcon[1..10]; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if ((idx >= 4'd1) && (idx <= 4'd10)) begin
            return RCON_TABLE[79 - 8 * (int'(idx) - 1) -: 8];
        end else begin
            return 8'h00;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
            r[103 - 32*c -: 8] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES key expansion: four new words derived from the key
// two (AES-256) or one (AES-128) round keys back and the most recent word.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [31:0]  last_word,
    input  logic         use_rot_rcon,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] temp_s;
    logic [31:0] w0_s, w1_s, w2_s, w3_s;

    // Word transform followed by the running XOR chain across the four words.
    always_comb begin
        if (use_rot_rcon) begin
            temp_s = sub_word({last_word[23:0], last_word[31:24]}) ^ {rcon, 24'h000000};
        end else begin
            temp_s = sub_word(last_word);
        end
        w0_s = prev_key[127:96] ^ temp_s;
        w1_s = prev_key[95:64]  ^ w0_s;
        w2_s = prev_key[63:32]  ^ w1_s;
        w3_s = prev_key[31:0]   ^ w2_s;
    end

    assign next_key = {w0_s, w1_s, w2_s, w3_s};

endmodule

// File: rtl/aes_enc_core_param.sv
// Iterative AES-128/256 encryption core, 1 or 3 clocks per round,
// valid/ready in and out, round keys expanded alongside the data path.
module aes_enc_core_param
    import aes_pkg::*;
#(
    parameter int ENABLE_256   = 1,
    parameter int ROUND_CYCLES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [255:0] in_key,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         busy
);

    generate
        if ((ROUND_CYCLES != 1) && (ROUND_CYCLES != 3)) begin : g_bad_round_cycles
            $error("aes_enc_core_param: ROUND_CYCLES must be 1 or 3");
        end
    endgenerate

    localparam logic [1:0] LAST_PHASE = 2'(ROUND_CYCLES - 1);

    aes_state_e   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   phase_q, phase_d;
    logic [127:0] state_q, state_d;
    logic [255:0] key_q, key_d;
    logic         mode_q, mode_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_mode_q, out_mode_d;

    logic         mode256_s, last_round_s;
    logic [127:0] sb_s, sr_s, mc_in_s, mc_s, result_s, round_key_s;
    logic [127:0] ks_prev_s, ks_next_s;
    logic [31:0]  ks_last_s;
    logic         ks_rot_s;
    logic [7:0]   ks_rcon_s;
    logic [255:0] key_next_s;

    assign mode256_s    = mode_q & (ENABLE_256 != 0);
    assign last_round_s = (round_q == (mode256_s ? NR_256 : NR_128));

    // Key window: AES-128 holds K(r-1) and derives K(r); AES-256 holds {K(r-1), K(r)}.
    always_comb begin
        ks_prev_s = key_q[255:128];
        if (mode256_s) begin
            ks_last_s   = key_q[31:0];
            ks_rot_s    = round_q[0];
            ks_rcon_s   = rcon((round_q + 4'd1) >> 1);
            round_key_s = key_q[127:0];
            key_next_s  = {key_q[127:0], ks_next_s};
        end else begin
            ks_last_s   = key_q[159:128];
            ks_rot_s    = 1'b1;
            ks_rcon_s   = rcon(round_q);
            round_key_s = ks_next_s;
            key_next_s  = {ks_next_s, 128'h0};
        end
    end

    aes_key_step u_key_step (
        .prev_key     (ks_prev_s),
        .last_word    (ks_last_s),
        .use_rot_rcon (ks_rot_s),
        .rcon         (ks_rcon_s),
        .next_key     (ks_next_s)
    );

    // Round datapath; the 3-cycle build feeds each stage from the state register.
    always_comb begin
        sb_s = sub_bytes(state_q);
        if (ROUND_CYCLES == 1) begin
            sr_s    = shift_rows(sb_s);
            mc_in_s = sr_s;
        end else begin
            sr_s    = shift_rows(state_q);
            mc_in_s = state_q;
        end
        if (last_round_s) begin
            mc_s = mc_in_s;
        end else begin
            mc_s = mix_columns(mc_in_s);
        end
        result_s = mc_s ^ round_key_s;
    end

    // Next-state logic; clear overrides both accept and the output handshake.
    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        phase_d     = phase_q;
        state_d     = state_q;
        key_d       = key_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        if (clear) begin
            fsm_d       = IDLE;
            out_valid_d = 1'b0;
            round_d     = 4'd0;
            phase_d     = 2'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = in_data ^ in_key[255:128];
                        key_d   = in_key;
                        mode_d  = in_mode & (ENABLE_256 != 0);
                        round_d = 4'd1;
                        phase_d = 2'd0;
                        fsm_d   = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
                ROUND: begin
                    if (phase_q == LAST_PHASE) begin
                        state_d = result_s;
                        key_d   = key_next_s;
                        phase_d = 2'd0;
                        if (last_round_s) begin
                            out_data_d  = result_s;
                            out_mode_d  = mode_q;
                            out_valid_d = 1'b1;
                            round_d     = 4'd0;
                            fsm_d       = DONE;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end else if (phase_q == 2'd0) begin
                        state_d = sb_s;
                        phase_d = phase_q + 2'd1;
                    end else begin
                        state_d = sr_s;
                        phase_d = phase_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        fsm_d       = IDLE;
                    end else begin
                        fsm_d = DONE;
                    end
                end
                default: begin
                    fsm_d       = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            phase_q     <= 2'd0;
            state_q     <= 128'h0;
            key_q       <= 256'h0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 128'h0;
            out_mode_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

endmodule
